multiplier_signed_arbiter: RTL
==============================

# multiplier_signed_arbiter

Shares one `multiplier_signed` datapath among `NREQ` requesters with round-robin arbitration and valid/ready handshakes. The multiplier is fully combinational, so it is wrapped in a two-register pipeline: an operand register in front and a product register behind. Results return on a single tagged response channel. The block sits between the core-side requesters (MAC units, address generators) and the shared multiplier.

## Interface
- `SIZE`, 32: operand width; passed to `multiplier_signed`.
- `NREQ`, 4: number of requesters, ≥2.
- `IDW`, `$clog2(NREQ)`: requester tag width (derived; do not override).

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: per-requester operand-valid.
- `req_ready` out NREQ: per-requester grant; one-hot or zero.
- `req_a` in NREQ*SIZE: signed multiplicand; requester i uses slice [i*SIZE +: SIZE].
- `req_b` in NREQ*SIZE: signed multiplier; same slicing as `req_a`.
- `rsp_valid` out 1: product valid.
- `rsp_ready` in 1: consumer accepts the product.
- `rsp_id` out IDW: index of the requester that issued the operands.
- `rsp_y` out 2*SIZE: signed product.

## Operation
- **Pipeline registers:**
  - S1 holds `s1_valid`, `s1_a`, `s1_b`, `s1_id`.
  - S2 holds `s2_valid`, `s2_y`, `s2_id`.
  - `rsp_*` are driven directly from S2.
- **Stall logic:**
  - `s2_adv = !s2_valid || rsp_ready`
  - `s1_adv = !s1_valid || s2_adv`
- **Arbitration:**
  - Active only when `s1_adv`.
  - Grant the first set bit of `req_valid`, scanning from `prio_ptr` upward and wrapping modulo NREQ.
  - `req_ready` is combinational from `req_valid`, `prio_ptr` and `s1_adv`.
  - It must be zero when `s1_adv` = 0. At most one bit is set.
- **Handshake:**
  - A transfer occurs on requester i when `req_valid[i] && req_ready[i]`.
  - A requester holds `req_a`/`req_b` stable while `req_valid` is high until the transfer.
  - `req_valid` may rise at any time. Dropping it before the transfer is permitted and loses nothing.
- **Pointer update:**
  - On a transfer to requester i, `prio_ptr` ← (i+1) mod NREQ.
  - Otherwise `prio_ptr` holds.
- **Register updates:**
  - S1 loads the granted operands and id when a transfer occurs and `s1_adv`.
  - S1 clears `s1_valid` when `s1_adv` and no transfer occurs.
  - S2 loads `multiplier_signed(s1_a, s1_b)` and `s1_id` when `s2_adv`; `s2_valid` ← `s1_valid`.
- **Arithmetic:**
  - Two's-complement, SIZE×SIZE → 2*SIZE, exact. No overflow is possible.
  - (−2^(SIZE−1))² = 2^(2*SIZE−2) must be produced exactly.
- **Response:**
  - While `rsp_valid` = 1 and `rsp_ready` = 0, `rsp_y` and `rsp_id` hold stable.
  - Responses are returned in grant order; ordering is global across requesters.
- **Reset:**
  - `s1_valid`, `s2_valid`, `rsp_valid` = 0.
  - `prio_ptr` = 0.
  - `rsp_y`, `rsp_id`, `s1_*` data = 0.
  - `req_ready` = 0 during the reset cycle.
- **Reset mid-operation:** all in-flight operations are discarded with no response. The first cycle after reset is a clean arbitration cycle with priority starting at requester 0.

## Timing
- Transfer at edge t → `rsp_valid` = 1 after edge t+2, i.e. 2-cycle latency with no backpressure.
- Throughput is 1 operation per cycle with `rsp_ready` held high.
- Backpressure:
  - With `rsp_ready` = 0, at most 2 operations are buffered (S1 + S2).
  - The third request sees `req_ready` = 0.
  - When `rsp_ready` rises, S2 drains and S1 and the arbiter advance in the same cycle. No bubble is inserted.
- Simultaneous requests: one grant per cycle. A requester with `req_valid` held waits at most NREQ−1 grants before it is granted.
- Combinational path `rsp_ready` → `req_ready` exists by design.
- The multiplier path lies only between S1 and S2.

## Test plan
- **Single op after reset:** requester 0 sends a = −3, b = 5 → 2 cycles later `rsp_valid` = 1, `rsp_id` = 0, `rsp_y` = 0xFFFF_FFFF_FFFF_FFF1.
- **Corner operands:**
  - 0x8000_0000 × 0x8000_0000 → 0x4000_0000_0000_0000.
  - 0x7FFF_FFFF × 0x8000_0000 → 0xC000_0000_8000_0000.
  - 0 × −1 → 0.
- **All four requesters hold `req_valid` high for 8 cycles, distinct operands, `rsp_ready` = 1:**
  - Grant order is 0, 1, 2, 3, 0, 1, 2, 3.
  - `rsp_id` follows that sequence 2 cycles later.
  - One response per cycle, with correct products.
- **Backpressure:** `rsp_ready` = 0 with requesters 1 and 2 streaming.
  - Two transfers occur, then `req_ready` = 0.
  - `rsp_y`/`rsp_id` stay stable for 5 cycles.
  - Raising `rsp_ready` drains in order with no loss or duplication.
- **Reset mid-operation:** assert `rst` for 1 cycle with S1 and S2 full.
  - No response appears.
  - The next grant with all requesting goes to requester 0.
- **Randomized soak:** 10k cycles, random `req_valid`/`rsp_ready`, random signed operands.
  - Scoreboard checks products and per-requester order.
  - Every continuously-valid requester is granted within NREQ grants.

Source files
------------

// File: rtl/multiplier_signed_arbiter.sv
// Round-robin shared signed multiplier with a two-stage
// operand/product pipeline and tagged responses.

module multiplier_signed #(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic [2*SIZE-1:0] y
);

  logic [2*SIZE-1:0] a_ext;
  logic [2*SIZE-1:0] b_ext;

  // Sign-extend to full width; the low 2*SIZE bits of the
  // wide product are then the exact two's-complement result.
  always_comb begin
    a_ext = {{SIZE{a[SIZE-1]}}, a};
    b_ext = {{SIZE{b[SIZE-1]}}, b};
    y     = a_ext * b_ext;
  end

endmodule

module multiplier_signed_arbiter #(
  parameter int SIZE = 32,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*SIZE-1:0] req_a,
  input  logic [NREQ*SIZE-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [2*SIZE-1:0]    rsp_y
);

  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST   = IDW'(NREQ-1);

  logic [IDW-1:0]    prio_ptr;

  logic              s1_valid;
  logic [SIZE-1:0]   s1_a;
  logic [SIZE-1:0]   s1_b;
  logic [IDW-1:0]    s1_id;

  logic              s2_valid;
  logic [2*SIZE-1:0] s2_y;
  logic [IDW-1:0]    s2_id;

  logic              s1_adv;
  logic              s2_adv;
  logic              xfer;

  logic [NREQ-1:0]   gnt_oh;
  logic [IDW-1:0]    gnt_id;
  logic              found;
  logic [IDW:0]      idx_ext;
  logic [IDW-1:0]    idx;

  logic [SIZE-1:0]   sel_a;
  logic [SIZE-1:0]   sel_b;
  logic [2*SIZE-1:0] mul_y;

  assign s2_adv = !s2_valid || rsp_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // Scan req_valid from prio_ptr upward, wrapping at NREQ.
  always_comb begin
    gnt_oh  = '0;
    gnt_id  = '0;
    found   = 1'b0;
    idx_ext = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_ext = {1'b0, prio_ptr} + (IDW+1)'(k);
      if (idx_ext >= NREQ_W) begin
        idx_ext = idx_ext - NREQ_W;
      end
      idx = idx_ext[IDW-1:0];
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        gnt_id      = idx;
        gnt_oh[idx] = 1'b1;
      end
    end
  end

  assign req_ready = (s1_adv && !rst) ? gnt_oh : '0;
  assign xfer      = |(req_valid & req_ready);

  // One-hot operand mux driven by the grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        sel_a = req_a[i*SIZE +: SIZE];
        sel_b = req_b[i*SIZE +: SIZE];
      end
    end
  end

  multiplier_signed #(
    .SIZE(SIZE)
  ) u_mul (
    .a(s1_a),
    .b(s1_b),
    .y(mul_y)
  );

  // Priority moves just past the most recent winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_ptr <= '0;
    end else if (xfer) begin
      prio_ptr <= (gnt_id == LAST) ? '0 : gnt_id + 1'b1;
    end
  end

  // Operand stage: capture the granted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (s1_adv) begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_a  <= sel_a;
        s1_b  <= sel_b;
        s1_id <= gnt_id;
      end
    end
  end

  // Product stage: register the multiplier output.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_id    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      s2_y     <= mul_y;
      s2_id    <= s1_id;
    end
  end

  assign rsp_valid = s2_valid;
  assign rsp_y     = s2_y;
  assign rsp_id    = s2_id;

endmodule
